// File: rtl/cavlc_pkg.sv
// Shared types and coeff_token VLC tables for the CAVLC encoder.
package cavlc_pkg;

   localparam int unsigned MAX_CODE_LEN = 16;
   localparam int unsigned LEN_W        = 5;
   localparam int unsigned TC_W         = 5;
   localparam int unsigned T1_W         = 2;

   // Which coeff_token table a token is coded with.
   typedef enum logic [2:0] {
      TBL_0_2   = 3'd0,
      TBL_2_4   = 3'd1,
      TBL_4_8   = 3'd2,
      TBL_FLC   = 3'd3,
      TBL_DC420 = 3'd4,
      TBL_DC422 = 3'd5
   } tbl_idx_e;

   // Stage-1 payload: decoded table plus raw counts.
   typedef struct packed {
      tbl_idx_e           tbl;
      logic [TC_W-1:0]    tc;
      logic [T1_W-1:0]    t1;
      logic               nc_err;
   } s1_tok_t;

   // Tables indexed by TotalCoeff*4 + TrailingOnes; codes are the low bits
   // of the codeword (the leading bits up to the length are zero).
   localparam logic [LEN_W-1:0] LEN_0_2 [68] = '{
       1, 0, 0, 0,   6, 2, 0, 0,   8, 6, 3, 0,   9, 8, 7, 5,  10, 9, 8, 6,
      11,10, 9, 7,  13,11,10, 8,  13,13,11, 9,  13,13,13,10,  14,14,13,11,
      14,14,14,13,  15,15,14,14,  15,15,15,14,  16,15,15,15,  16,16,16,15,
      16,16,16,16,  16,16,16,16};
   localparam logic [3:0] CODE_0_2 [68] = '{
       1, 0, 0, 0,   5, 1, 0, 0,   7, 4, 1, 0,   7, 6, 5, 3,   7, 6, 5, 3,
       7, 6, 5, 4,  15, 6, 5, 4,  11,14, 5, 4,   8,10,13, 4,  15,14, 9, 4,
      11,10,13,12,  15,14, 9,12,  11,10,13, 8,  15, 1, 9,12,  11,14,13, 8,
       7,10, 9,12,   4, 6, 5, 8};

   localparam logic [LEN_W-1:0] LEN_2_4 [68] = '{
       2, 0, 0, 0,   6, 2, 0, 0,   6, 5, 3, 0,   7, 6, 6, 4,   8, 6, 6, 4,
       8, 7, 7, 5,   9, 8, 8, 6,  11, 9, 9, 6,  11,11,11, 7,  12,11,11, 9,
      12,12,12,11,  12,12,12,11,  13,13,13,12,  13,13,13,13,  13,14,13,13,
      14,14,14,13,  14,14,14,14};
   localparam logic [3:0] CODE_2_4 [68] = '{
       3, 0, 0, 0,  11, 2, 0, 0,   7, 7, 3, 0,   7,10, 9, 5,   7, 6, 5, 4,
       4, 6, 5, 6,   7, 6, 5, 8,  15, 6, 5, 4,  11,14,13, 4,  15,10, 9, 4,
      11,14,13,12,   8,10, 9, 8,  15,14,13,12,  11,10, 9,12,   7,11, 6, 8,
       9, 8,10, 1,   7, 6, 5, 4};

   localparam logic [LEN_W-1:0] LEN_4_8 [68] = '{
       4, 0, 0, 0,   6, 4, 0, 0,   6, 5, 4, 0,   6, 5, 5, 4,   7, 5, 5, 4,
       7, 5, 5, 4,   7, 6, 6, 4,   7, 6, 6, 4,   8, 7, 7, 5,   8, 8, 7, 6,
       9, 8, 8, 7,   9, 9, 8, 8,   9, 9, 9, 8,  10, 9, 9, 9,  10,10,10,10,
      10,10,10,10,  10,10,10,10};
   localparam logic [3:0] CODE_4_8 [68] = '{
      15, 0, 0, 0,  15,14, 0, 0,  11,15,13, 0,   8,12,14,12,  15,10,11,11,
      11, 8, 9,10,   9,14,13, 9,   8,10, 9, 8,  15,14,13,13,  11,14,10,12,
      15,10,13,12,  11,14, 9,12,   8,10,13, 8,  13, 7, 9,12,   9,12,11,10,
       5, 8, 7, 6,   1, 4, 3, 2};

   localparam logic [LEN_W-1:0] LEN_DC420 [20] = '{
       2, 0, 0, 0,   6, 1, 0, 0,   6, 6, 3, 0,   6, 7, 7, 6,   6, 8, 8, 7};
   localparam logic [3:0] CODE_DC420 [20] = '{
       1, 0, 0, 0,   7, 1, 0, 0,   4, 6, 1, 0,   3, 3, 2, 5,   2, 3, 2, 0};

   localparam logic [LEN_W-1:0] LEN_DC422 [36] = '{
       1, 0, 0, 0,   7, 2, 0, 0,   7, 7, 3, 0,   9, 7, 7, 5,   9, 9, 7, 6,
      10,10, 9, 7,  11,11,10, 7,  12,12,11,10,  13,12,12,11};
   localparam logic [3:0] CODE_DC422 [36] = '{
       1, 0, 0, 0,  15, 1, 0, 0,  14,13, 1, 0,   7,12,11, 1,   6, 5,10, 1,
       7, 6, 4, 9,   7, 6, 5, 8,   7, 6, 5, 4,   7, 5, 4, 4};

endpackage

// File: rtl/coeff_token_lut.sv
// Combinational coeff_token lookup: (table, TotalCoeff, TrailingOnes) -> codeword.
module coeff_token_lut
   import cavlc_pkg::*;
#(
   parameter int unsigned CODE_W = 16
) (
   input  tbl_idx_e          tbl_idx,
   input  logic [TC_W-1:0]   tc,
   input  logic [T1_W-1:0]   t1,
   output logic [CODE_W-1:0] code,
   output logic [LEN_W-1:0]  len,
   output logic              err
);

   logic [6:0]      idx68;
   logic [5:0]      idx36;
   logic [4:0]      idx20;
   logic [TC_W-1:0] max_tc;

   assign idx68 = {tc, t1};
   assign idx36 = {tc[3:0], t1};
   assign idx20 = {tc[2:0], t1};

   // Range check per table, then table select; error tokens stay all-zero.
   always_comb begin
      code   = '0;
      len    = '0;
      err    = 1'b0;
      max_tc = TC_W'(16);
      case (tbl_idx)
         TBL_DC420: max_tc = TC_W'(4);
         TBL_DC422: max_tc = TC_W'(8);
         default:   max_tc = TC_W'(16);
      endcase
      err = (tc > max_tc) || ({3'b000, t1} > tc);
      if (!err) begin
         case (tbl_idx)
            TBL_0_2: begin
               len  = LEN_0_2[idx68];
               code = CODE_W'(CODE_0_2[idx68]);
            end
            TBL_2_4: begin
               len  = LEN_2_4[idx68];
               code = CODE_W'(CODE_2_4[idx68]);
            end
            TBL_4_8: begin
               len  = LEN_4_8[idx68];
               code = CODE_W'(CODE_4_8[idx68]);
            end
            TBL_FLC: begin
               len  = LEN_W'(6);
               code = (tc == '0) ? CODE_W'(6'b000011)
                                 : CODE_W'({4'(tc - TC_W'(1)), t1});
            end
            TBL_DC420: begin
               len  = LEN_DC420[idx20];
               code = CODE_W'(CODE_DC420[idx20]);
            end
            TBL_DC422: begin
               len  = LEN_DC422[idx36];
               code = CODE_W'(CODE_DC422[idx36]);
            end
            default: err = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/coeff_token_enc_pipe.sv
// Two-stage elastic coeff_token encoder with running bit-count accumulator.
module coeff_token_enc_pipe
   import cavlc_pkg::*;
#(
   parameter int unsigned CODE_W       = 16,
   parameter int unsigned NC_W         = 6,
   parameter bit          CHROMA422_EN = 1'b1,
   parameter int unsigned ACC_W        = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [NC_W-1:0] in_nc,
   input  logic [TC_W-1:0]        in_total_coeff,
   input  logic [T1_W-1:0]        in_trail_ones,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CODE_W-1:0]      out_code,
   output logic [LEN_W-1:0]       out_len,
   output logic                   out_err,
   input  logic                   acc_clr,
   output logic [ACC_W-1:0]       acc_bits
);

   localparam logic signed [NC_W-1:0] NC_M2 = NC_W'(-2);
   localparam logic signed [NC_W-1:0] NC_M1 = NC_W'(-1);
   localparam logic signed [NC_W-1:0] NC_2  = NC_W'(2);
   localparam logic signed [NC_W-1:0] NC_4  = NC_W'(4);
   localparam logic signed [NC_W-1:0] NC_8  = NC_W'(8);

   logic                s1_valid;
   s1_tok_t             s1;
   s1_tok_t             s1_nxt;
   logic                s1_adv;
   logic                s2_adv;
   logic [CODE_W-1:0]   lut_code;
   logic [LEN_W-1:0]    lut_len;
   logic                lut_err;

   // A stage advances when it is empty or its downstream advances.
   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   // nC -> table index; out-of-range nC is flagged here and carried along.
   always_comb begin
      s1_nxt     = '0;
      s1_nxt.tbl = TBL_0_2;
      s1_nxt.tc  = in_total_coeff;
      s1_nxt.t1  = in_trail_ones;
      if (in_nc < NC_M2) begin
         s1_nxt.nc_err = 1'b1;
      end else if (in_nc == NC_M2) begin
         s1_nxt.tbl    = TBL_DC422;
         s1_nxt.nc_err = !CHROMA422_EN;
      end else if (in_nc == NC_M1) begin
         s1_nxt.tbl = TBL_DC420;
      end else if (in_nc < NC_2) begin
         s1_nxt.tbl = TBL_0_2;
      end else if (in_nc < NC_4) begin
         s1_nxt.tbl = TBL_2_4;
      end else if (in_nc < NC_8) begin
         s1_nxt.tbl = TBL_4_8;
      end else begin
         s1_nxt.tbl = TBL_FLC;
      end
   end

   coeff_token_lut #(
      .CODE_W (CODE_W)
   ) u_lut (
      .tbl_idx (s1.tbl),
      .tc      (s1.tc),
      .t1      (s1.t1),
      .code    (lut_code),
      .len     (lut_len),
      .err     (lut_err)
   );

   // Stage 1 captures the decoded request; stage 2 registers the lookup.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1        <= '0;
         out_valid <= 1'b0;
         out_code  <= '0;
         out_len   <= '0;
         out_err   <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_valid <= in_valid;
            s1       <= s1_nxt;
         end
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_err  <= s1.nc_err || lut_err;
               out_code <= s1.nc_err ? '0 : lut_code;
               out_len  <= s1.nc_err ? '0 : lut_len;
            end
         end
      end
   end

   // Bit accumulator: clear takes effect before a coincident transfer adds.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_bits <= '0;
      end else if (out_valid && out_ready) begin
         acc_bits <= (acc_clr ? '0 : acc_bits) + ACC_W'(out_len);
      end else if (acc_clr) begin
         acc_bits <= '0;
      end
   end

endmodule

// File: tb/tb_coeff_token_enc_pipe.sv
// Randomised and directed bench for coeff_token_enc_pipe with a queue scoreboard.
module tb_coeff_token_enc_pipe;

   localparam int unsigned CODE_W       = 16;
   localparam int unsigned NC_W         = 6;
   localparam bit          CHROMA422_EN = 1'b1;
   localparam int unsigned ACC_W        = 16;

   typedef struct {
      int err;
      int len;
      int code;
   } tok_t;

   logic                   clk;
   logic                   rst;
   logic                   in_valid;
   logic                   in_ready;
   logic signed [NC_W-1:0] in_nc;
   logic [4:0]             in_total_coeff;
   logic [1:0]             in_trail_ones;
   logic                   out_valid;
   logic                   out_ready;
   logic [CODE_W-1:0]      out_code;
   logic [4:0]             out_len;
   logic                   out_err;
   logic                   acc_clr;
   logic [ACC_W-1:0]       acc_bits;

   int n_checks = 0;
   int n_fail   = 0;
   int out_cnt  = 0;

   tok_t              exp_q[$];
   logic [ACC_W-1:0]  acc_model;
   bit                stall_prev = 1'b0;
   int                held_code, held_len, held_err;

   // Reference tables in the standard's (TotalCoeff, TrailingOnes) order.
   int vlc_len [3][68] = '{
      '{ 1, 0, 0, 0,  6, 2, 0, 0,  8, 6, 3, 0,  9, 8, 7, 5, 10, 9, 8, 6,
        11,10, 9, 7, 13,11,10, 8, 13,13,11, 9, 13,13,13,10, 14,14,13,11,
        14,14,14,13, 15,15,14,14, 15,15,15,14, 16,15,15,15, 16,16,16,15,
        16,16,16,16, 16,16,16,16},
      '{ 2, 0, 0, 0,  6, 2, 0, 0,  6, 5, 3, 0,  7, 6, 6, 4,  8, 6, 6, 4,
         8, 7, 7, 5,  9, 8, 8, 6, 11, 9, 9, 6, 11,11,11, 7, 12,11,11, 9,
        12,12,12,11, 12,12,12,11, 13,13,13,12, 13,13,13,13, 13,14,13,13,
        14,14,14,13, 14,14,14,14},
      '{ 4, 0, 0, 0,  6, 4, 0, 0,  6, 5, 4, 0,  6, 5, 5, 4,  7, 5, 5, 4,
         7, 5, 5, 4,  7, 6, 6, 4,  7, 6, 6, 4,  8, 7, 7, 5,  8, 8, 7, 6,
         9, 8, 8, 7,  9, 9, 8, 8,  9, 9, 9, 8, 10, 9, 9, 9, 10,10,10,10,
        10,10,10,10, 10,10,10,10}};
   int vlc_code [3][68] = '{
      '{ 1, 0, 0, 0,  5, 1, 0, 0,  7, 4, 1, 0,  7, 6, 5, 3,  7, 6, 5, 3,
         7, 6, 5, 4, 15, 6, 5, 4, 11,14, 5, 4,  8,10,13, 4, 15,14, 9, 4,
        11,10,13,12, 15,14, 9,12, 11,10,13, 8, 15, 1, 9,12, 11,14,13, 8,
         7,10, 9,12,  4, 6, 5, 8},
      '{ 3, 0, 0, 0, 11, 2, 0, 0,  7, 7, 3, 0,  7,10, 9, 5,  7, 6, 5, 4,
         4, 6, 5, 6,  7, 6, 5, 8, 15, 6, 5, 4, 11,14,13, 4, 15,10, 9, 4,
        11,14,13,12,  8,10, 9, 8, 15,14,13,12, 11,10, 9,12,  7,11, 6, 8,
         9, 8,10, 1,  7, 6, 5, 4},
      '{15, 0, 0, 0, 15,14, 0, 0, 11,15,13, 0,  8,12,14,12, 15,10,11,11,
        11, 8, 9,10,  9,14,13, 9,  8,10, 9, 8, 15,14,13,13, 11,14,10,12,
        15,10,13,12, 11,14, 9,12,  8,10,13, 8, 13, 7, 9,12,  9,12,11,10,
         5, 8, 7, 6,  1, 4, 3, 2}};
   int dc420_len  [20] = '{2,0,0,0, 6,1,0,0, 6,6,3,0, 6,7,7,6, 6,8,8,7};
   int dc420_code [20] = '{1,0,0,0, 7,1,0,0, 4,6,1,0, 3,3,2,5, 2,3,2,0};
   int dc422_len  [36] = '{1,0,0,0, 7,2,0,0, 7,7,3,0, 9,7,7,5, 9,9,7,6,
                           10,10,9,7, 11,11,10,7, 12,12,11,10, 13,12,12,11};
   int dc422_code [36] = '{1,0,0,0, 15,1,0,0, 14,13,1,0, 7,12,11,1, 6,5,10,1,
                           7,6,4,9, 7,6,5,8, 7,6,5,4, 7,5,4,4};

   coeff_token_enc_pipe #(
      .CODE_W       (CODE_W),
      .NC_W         (NC_W),
      .CHROMA422_EN (CHROMA422_EN),
      .ACC_W        (ACC_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_nc          (in_nc),
      .in_total_coeff (in_total_coeff),
      .in_trail_ones  (in_trail_ones),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_code       (out_code),
      .out_len        (out_len),
      .out_err        (out_err),
      .acc_clr        (acc_clr),
      .acc_bits       (acc_bits)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Expected token from nC / TotalCoeff / TrailingOnes using the table rules.
   function automatic tok_t model(input int n, input int tc, input int t1);
      tok_t r;
      int   mx;
      int   k;
      r.err = 1; r.len = 0; r.code = 0;
      if (n < -2 || (n == -2 && !CHROMA422_EN)) return r;
      mx = (n == -1) ? 4 : (n == -2) ? 8 : 16;
      if (tc > mx || t1 > tc) return r;
      r.err = 0;
      if (n >= 8) begin
         r.len  = 6;
         r.code = (tc == 0) ? 3 : (tc - 1) * 4 + t1;
      end else if (n == -1) begin
         r.len  = dc420_len[tc*4 + t1];
         r.code = dc420_code[tc*4 + t1];
      end else if (n == -2) begin
         r.len  = dc422_len[tc*4 + t1];
         r.code = dc422_code[tc*4 + t1];
      end else begin
         k      = (n < 2) ? 0 : (n < 4) ? 1 : 2;
         r.len  = vlc_len[k][tc*4 + t1];
         r.code = vlc_code[k][tc*4 + t1];
      end
      return r;
   endfunction

   // Scoreboard: ordering, data, stall stability, in_ready and accumulator.
   always @(negedge clk) begin
      tok_t e;
      if (rst) begin
         exp_q.delete();
         acc_model  = '0;
         stall_prev = 1'b0;
      end else begin
         check_eq("acc_bits", int'(acc_bits), int'(acc_model));
         check_eq("in_ready", int'(in_ready), (exp_q.size() == 2 && !out_ready) ? 0 : 1);
         if (stall_prev) begin
            check_eq("stall_valid", int'(out_valid), 1);
            check_eq("stall_code", int'(out_code), held_code);
            check_eq("stall_len", int'(out_len), held_len);
            check_eq("stall_err", int'(out_err), held_err);
         end
         if (out_valid && out_ready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
               check_eq("out_extra", int'(out_valid), 0);
            end else begin
               e = exp_q.pop_front();
               check_eq("sb_code", int'(out_code), e.code);
               check_eq("sb_len", int'(out_len), e.len);
               check_eq("sb_err", int'(out_err), e.err);
               acc_model = (acc_clr ? '0 : acc_model) + ACC_W'(e.len);
            end
         end else if (acc_clr) begin
            acc_model = '0;
         end
         if (in_valid && in_ready)
            exp_q.push_back(model(int'(in_nc), int'(in_total_coeff), int'(in_trail_ones)));
         stall_prev = out_valid && !out_ready;
         held_code  = int'(out_code);
         held_len   = int'(out_len);
         held_err   = int'(out_err);
      end
   end

   // Single token into an empty pipe; checks the 2-edge latency and result.
   task automatic lat_token(input string tag, input int nc, input int tc, input int t1,
                            input int ecode, input int elen, input int eerr, input bit clr);
      @(posedge clk); #1;
      in_valid       = 1'b1;
      in_nc          = NC_W'(nc);
      in_total_coeff = 5'(tc);
      in_trail_ones  = 2'(t1);
      out_ready      = 1'b1;
      @(negedge clk);
      check_eq({tag, "_in_ready"}, int'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check_eq({tag, "_early"}, int'(out_valid), 0);
      @(posedge clk); #1;
      acc_clr = clr;
      @(negedge clk);
      check_eq({tag, "_valid"}, int'(out_valid), 1);
      check_eq({tag, "_code"}, int'(out_code), ecode);
      check_eq({tag, "_len"}, int'(out_len), elen);
      check_eq({tag, "_err"}, int'(out_err), eerr);
      @(posedge clk); #1;
      acc_clr = 1'b0;
   endtask

   task automatic rand_token(input bit legal);
      int tc;
      if (legal) begin
         in_nc = NC_W'($urandom_range(0, 12));
         tc    = $urandom_range(0, 16);
         in_total_coeff = 5'(tc);
         in_trail_ones  = 2'($urandom_range(0, (tc < 3) ? tc : 3));
      end else begin
         in_nc = NC_W'(int'($urandom_range(0, 24)) - 4);
         in_total_coeff = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(17, 31))
                                                       : 5'($urandom_range(0, 16));
         in_trail_ones  = 2'($urandom_range(0, 3));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt0;
      int idx;
      int n_acc;
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

      rst = 1'b1; in_valid = 1'b0; in_nc = '0; in_total_coeff = '0;
      in_trail_ones = '0; out_ready = 1'b1; acc_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("rst_out_valid", int'(out_valid), 0);
      check_eq("rst_out_code", int'(out_code), 0);
      check_eq("rst_out_len", int'(out_len), 0);
      check_eq("rst_out_err", int'(out_err), 0);
      check_eq("rst_acc", int'(acc_bits), 0);
      check_eq("rst_in_ready", int'(in_ready), 1);

      lat_token("nc0_tc1_t1", 0, 1, 1, 1, 2, 0, 1'b0);
      lat_token("nc0_tc1_t0", 0, 1, 0, 5, 6, 0, 1'b0);
      lat_token("nc0_tc0", 0, 0, 0, 1, 1, 0, 1'b0);
      lat_token("nc3_tc0", 3, 0, 0, 3, 2, 0, 1'b0);
      lat_token("nc5_tc1_t1", 5, 1, 1, 14, 4, 0, 1'b0);
      lat_token("nc9_tc16_t3", 9, 16, 3, 63, 6, 0, 1'b0);
      lat_token("nc8_tc0", 8, 0, 0, 3, 6, 0, 1'b0);
      lat_token("ncm1_tc1_t1", -1, 1, 1, 1, 1, 0, 1'b0);
      lat_token("ncm1_tc5", -1, 5, 0, 0, 0, 1, 1'b0);
      lat_token("nc0_t1_gt_tc", 0, 1, 2, 0, 0, 1, 1'b0);
      lat_token("ncm3", -3, 0, 0, 0, 0, 1, 1'b0);
      lat_token("ncm2_tc9", -2, 9, 0, 0, 0, 1, 1'b0);
      lat_token("ncm2_tc0", -2, 0, 0, 1, 1, 0, 1'b0);
      lat_token("nc0_tc17", 0, 17, 0, 0, 0, 1, 1'b0);

      // Accumulator: clear, add 1+2+6, then clear coincident with a len-4 transfer.
      @(posedge clk); #1 acc_clr = 1'b1;
      @(posedge clk); #1 acc_clr = 1'b0;
      lat_token("acc_a", 0, 0, 0, 1, 1, 0, 1'b0);
      lat_token("acc_b", 0, 1, 1, 1, 2, 0, 1'b0);
      lat_token("acc_c", 0, 1, 0, 5, 6, 0, 1'b0);
      @(negedge clk);
      check_eq("acc_sum9", int'(acc_bits), 9);
      lat_token("acc_d", 5, 1, 1, 14, 4, 0, 1'b1);
      @(negedge clk);
      check_eq("acc_clr_add4", int'(acc_bits), 4);

      // Back-to-back 8 tokens with out_ready pattern 1,0,0,1.
      cnt0 = out_cnt;
      idx  = 0;
      for (int cyc = 0; cyc < 64 && idx < 8; cyc++) begin
         @(posedge clk); #1;
         in_valid  = 1'b1;
         out_ready = pat[cyc % 4];
         if (cyc == 0 || in_ready) rand_token(1'b1);
         @(negedge clk);
         if (in_ready) idx++;
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_eq("b2b_accepted", idx, 8);
      check_eq("b2b_emitted", out_cnt - cnt0, 8);

      // Stall from empty: exactly two accepts before in_ready falls.
      n_acc = 0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      rand_token(1'b1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (!in_ready) break;
         n_acc++;
         @(posedge clk); #1;
         rand_token(1'b1);
      end
      check_eq("stall_accepts", n_acc, 2);

      // Reset with both stages full.
      @(posedge clk); #1;
      rst      = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst2_out_valid", int'(out_valid), 0);
      check_eq("rst2_acc", int'(acc_bits), 0);
      check_eq("rst2_in_ready", int'(in_ready), 1);
      lat_token("post_rst", 5, 1, 1, 14, 4, 0, 1'b0);

      // Random traffic against the scoreboard.
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         acc_clr   = ($urandom_range(0, 19) == 0);
         rand_token(1'b0);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      acc_clr   = 1'b0;
      for (int c = 0; c < 10 && exp_q.size() != 0; c++) @(posedge clk);
      #1;
      check_eq("drain_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
